// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out shift register.
// A load strobe captures an N-bit word. The word then leaves on serial_out one
// bit per clock, MSB first by default. busy and done let a controller pace the
// next word without counting cycles itself.
module piso_shift_register #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] data_in,
  output logic         serial_out,
  output logic         busy,
  output logic         done
);

  // Wide enough to hold N itself, because a fresh load sets the count to N.
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [N-1:0]  sh_r;
  logic [N-1:0]  sh_shift_s;
  logic [CW-1:0] cnt_r;
  logic          done_r;

  // Shift direction and output tap are fixed at elaboration, not muxed at run time.
  // Vacated positions always fill with zero, so an idle register drains to zero.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sh_shift_s = {sh_r[N-2:0], 1'b0};
      assign serial_out = sh_r[N-1];
    end else begin : g_lsb_first
      assign sh_shift_s = {1'b0, sh_r[N-1:1]};
      assign serial_out = sh_r[0];
    end
  endgenerate

  // State update. Reset has priority over load, and load has priority over shift.
  // done is set only on a shift edge that consumes the last bit. A reload or a
  // reset therefore abandons the word in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_r   <= {N{1'b0}};
      cnt_r  <= CNT_ZERO;
      done_r <= 1'b0;
    end else if (load) begin
      sh_r   <= data_in;
      cnt_r  <= CNT_LOAD;
      done_r <= 1'b0;
    end else begin
      sh_r   <= sh_shift_s;
      cnt_r  <= (cnt_r != CNT_ZERO) ? (cnt_r - CNT_ONE) : CNT_ZERO;
      done_r <= (cnt_r == CNT_ONE);
    end
  end

  assign busy = (cnt_r != CNT_ZERO);
  assign done = done_r;

endmodule

// File: tb/tb_piso_shift_register.sv
// Self-checking bench for piso_shift_register.
// Two instances run side by side: one with N=8 MSB-first and one with N=8 LSB-first.
// Each is compared against a queue model of the bits still to be sent.
module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       so_m, busy_m, done_m;
  logic       so_l, busy_l, done_l;

  int errors = 0;
  int checks = 0;
  int done_seen_m = 0;

  // Model state: the bits still to appear, in transmit order, plus the expected done flag.
  bit qm[$];
  bit ql[$];
  bit dm_exp = 1'b0;
  bit dl_exp = 1'b0;

  always #5 clk = ~clk;

  piso_shift_register #(.N(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .serial_out(so_m), .busy(busy_m), .done(done_m)
  );

  piso_shift_register #(.N(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .serial_out(so_l), .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one rising edge, using the inputs that were present at that edge.
  task automatic model_edge(input logic r, input logic l, input logic [7:0] d);
    if (r) begin
      qm.delete(); ql.delete();
      dm_exp = 1'b0; dl_exp = 1'b0;
    end else if (l) begin
      qm.delete(); ql.delete();
      for (int i = 0; i < 8; i++) begin
        qm.push_back(d[7-i]);
        ql.push_back(d[i]);
      end
      dm_exp = 1'b0; dl_exp = 1'b0;
    end else begin
      dm_exp = (qm.size() == 1);
      dl_exp = (ql.size() == 1);
      if (qm.size() != 0) void'(qm.pop_front());
      if (ql.size() != 0) void'(ql.pop_front());
    end
  endtask

  // Apply one cycle of inputs, clock it, then compare every output on the falling edge.
  task automatic step(input logic r, input logic l, input logic [7:0] d);
    reset = r; load = l; data_in = d;
    @(posedge clk);
    model_edge(r, l, d);
    @(negedge clk);
    chk("msb_serial", so_m, (qm.size() != 0) ? qm[0] : 1'b0);
    chk("msb_busy", busy_m, qm.size() != 0);
    chk("msb_done", done_m, dm_exp);
    chk("lsb_serial", so_l, (ql.size() != 0) ? ql[0] : 1'b0);
    chk("lsb_busy", busy_l, ql.size() != 0);
    chk("lsb_done", done_l, dl_exp);
    if (done_m === 1'b1) done_seen_m++;
  endtask

  initial begin
    logic [7:0] rd;
    @(negedge clk);

    // Reset held for two cycles while load and all-ones data are also applied.
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hFF);

    // One word shifted out completely; the LSB-first instance sees the same load.
    step(1'b0, 1'b1, 8'b10101010);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'b11001010);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);

    // Reload mid-word: the first word is abandoned and only one done pulse appears.
    done_seen_m = 0;
    step(1'b0, 1'b1, 8'hF0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h0F);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);
    chk_int("reload_done_count", done_seen_m, 1);

    // Reset mid-word: no done pulse follows.
    done_seen_m = 0;
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);
    chk_int("reset_mid_done_count", done_seen_m, 0);

    // Back-to-back words: the second load lands on the edge where the first word ends.
    done_seen_m = 0;
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);
    chk_int("b2b_done_count", done_seen_m, 1);

    // Randomised traffic: occasional resets and loads, mostly shifting.
    for (int i = 0; i < 400; i++) begin
      rd = 8'($urandom);
      step(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
